mem_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single memory port (`data`/`addr`/`wr_rd`/`rst` in, `data_out` back) between N requesters. Each accepted request issues one single-beat write or read to the memory port. Read data returning after a fixed latency is routed back to the requester that issued the read. The block sits between the requesting agents (drivers/masters) and the memory DUT, and owns the memory port exclusively.

---
 rtl/mem_port_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one registered memory port between N requesters.
// Read responses are steered back to their issuer through a tag pipeline that
// is RD_LAT+1 stages deep, so responses come back in issue order.
//
// Handshake: req[k] acts as "valid" and gnt[k] as "accept". A requester holds
// req/req_wr_rd/req_addr/req_data stable until it sees gnt[k] high. The
// transfer happens in that same cycle, when the arbiter samples its fields.
// gnt is never high while rst is high.
module mem_port_arbiter #(
  parameter int N      = 4,
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_wr_rd,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_data,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    rvalid,
  output logic [DW-1:0]   rdata,
  output logic            mem_en,
  output logic            mem_wr_rd,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_data,
  input  logic [DW-1:0]   mem_data_out
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0]            ptr;
  logic [PW-1:0]            win;
  logic [PW-1:0]            ptr_nxt;
  logic                     found;
  logic                     take;
  logic [N-1:0]             rv_next;
  logic [RD_LAT:0]          tag_v;
  logic [RD_LAT:0][PW-1:0]  tag_id;

  // Scan from ptr upward (wrapping) and pick the first active request.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // One-hot grant, suppressed during reset; winner becomes lowest priority next.
  always_comb begin
    gnt     = '0;
    take    = found && !rst;
    ptr_nxt = PW'((int'(win) + 1) % N);
    if (take) gnt[win] = 1'b1;
  end

  // Decode the tag leaving the last pipeline stage into a one-hot response.
  always_comb begin
    rv_next = '0;
    if (tag_v[RD_LAT]) rv_next[tag_id[RD_LAT]] = 1'b1;
  end

  // Priority pointer: advances past the winner, holds when nobody asks.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (take) begin
      ptr <= ptr_nxt;
    end
  end

  // Memory port register: one access issued in the cycle after each grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_wr_rd <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
    end else begin
      mem_en <= take;
      if (take) begin
        mem_wr_rd <= req_wr_rd[win];
        mem_addr  <= req_addr[int'(win)*AW +: AW];
        mem_data  <= req_data[int'(win)*DW +: DW];
      end
    end
  end

  // Tag pipeline: a read pushes {1,id}, a write or idle cycle pushes a bubble.
  // Stage RD_LAT lines up with the cycle in which mem_data_out is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[RD_LAT-1:0], take && !req_wr_rd[win]};
      tag_id <= {tag_id[RD_LAT-1:0], win};
    end
  end

  // Response register: rdata only reloads when a read tag emerges.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      rvalid <= rv_next;
      if (tag_v[RD_LAT]) rdata <= mem_data_out;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter with a small memory model on
// the memory port and an expected-response queue for read returns.
module tb_mem_port_arbiter;

  localparam int N      = 4;
  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    req;
  logic [N-1:0]    req_wr_rd;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    gnt;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic            mem_en;
  logic            mem_wr_rd;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_data;
  logic [DW-1:0]   mem_data_out;

  mem_port_arbiter #(.N(N), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_wr_rd    (req_wr_rd),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_en       (mem_en),
    .mem_wr_rd    (mem_wr_rd),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_data_out (mem_data_out)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model on the port: writes land on the edge, reads return RD_LAT later.
  logic [31:0] mem_model [256];
  logic [31:0] rd_pipe0;
  logic [31:0] rd_pipe1;
  initial for (int i = 0; i < 256; i++) mem_model[i] = 32'hA5A5_0000 | i;
  always @(posedge clk) begin
    if (mem_en === 1'b1 && mem_wr_rd === 1'b1) mem_model[mem_addr[7:0]] <= mem_data;
    rd_pipe0 <= mem_model[mem_addr[7:0]];
    rd_pipe1 <= rd_pipe0;
  end
  assign mem_data_out = rd_pipe1;

  // Scoreboard state: {due_cycle[15:0], id[3:0], data[31:0]}
  logic [51:0] exp_q[$];
  logic [31:0] ref_mem [256];
  int          tests;
  int          fails;
  int          cyc;
  int          m_ptr;
  logic        armed;
  logic        exp_zero;
  logic        exp_en;
  logic        exp_wr;
  logic [31:0] exp_addr;
  logic [31:0] exp_data;
  logic [31:0] last_rdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int k);
    logic [N-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [N-1:0] rr_pick(input int p, input logic [N-1:0] r);
    for (int i = 0; i < N; i++) begin
      int j;
      j = (p + i) % N;
      if (r[j]) return onehot(j);
    end
    return '0;
  endfunction

  task automatic set_port(input int k, input logic [31:0] a, input logic [31:0] d);
    req_addr[k*AW +: AW] = a;
    req_data[k*DW +: DW] = d;
  endtask

  // One clock cycle: drive, check port/response/grant at negedge, record expectations.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] wr,
                      input logic [N-1:0] exp_g, input string tag);
    logic [51:0] e;
    int k;
    rst = r;
    req = rq;
    req_wr_rd = wr;
    @(negedge clk);
    if (armed) begin
      if (exp_zero) begin
        chk({tag, "_rst_mem_en"}, 64'(mem_en), 64'd0);
        chk({tag, "_rst_mem_wr_rd"}, 64'(mem_wr_rd), 64'd0);
        chk({tag, "_rst_mem_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_rst_mem_data"}, 64'(mem_data), 64'd0);
      end else begin
        chk({tag, "_mem_en"}, 64'(mem_en), 64'(exp_en));
        if (exp_en) begin
          chk({tag, "_mem_wr_rd"}, 64'(mem_wr_rd), 64'(exp_wr));
          chk({tag, "_mem_addr"}, 64'(mem_addr), 64'(exp_addr));
          chk({tag, "_mem_data"}, 64'(mem_data), 64'(exp_data));
        end
      end
      if (exp_q.size() > 0 && exp_q[0][51:36] == cyc[15:0]) begin
        e = exp_q.pop_front();
        chk({tag, "_rvalid"}, 64'(rvalid), 64'(onehot(int'(e[35:32]))));
        chk({tag, "_rdata"}, 64'(rdata), 64'(e[31:0]));
        last_rdata = e[31:0];
      end else begin
        chk({tag, "_rvalid_idle"}, 64'(rvalid), 64'd0);
        chk({tag, "_rdata_hold"}, 64'(rdata), 64'(last_rdata));
      end
    end
    chk({tag, "_gnt"}, 64'(gnt), 64'(exp_g));
    exp_en   = 1'b0;
    exp_zero = r;
    if (r) begin
      armed      = 1'b1;
      last_rdata = '0;
      m_ptr      = 0;
      exp_q.delete();
    end else if (exp_g != '0) begin
      k = 0;
      for (int i = 0; i < N; i++) if (exp_g[i]) k = i;
      exp_en   = 1'b1;
      exp_wr   = wr[k];
      exp_addr = req_addr[k*AW +: AW];
      exp_data = req_data[k*DW +: DW];
      if (exp_wr) ref_mem[exp_addr[7:0]] = exp_data;
      else exp_q.push_back({16'(cyc + RD_LAT + 2), 4'(k), ref_mem[exp_addr[7:0]]});
      m_ptr = (k + 1) % N;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] wr;
    tests = 0; fails = 0; cyc = 0; m_ptr = 0;
    armed = 1'b0; exp_zero = 1'b0; exp_en = 1'b0; exp_wr = 1'b0;
    exp_addr = '0; exp_data = '0; last_rdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'hA5A5_0000 | i;
    rst = 1'b1; req = '0; req_wr_rd = '0; req_addr = '0; req_data = '0;

    // Reset with all requests asserted: no grants, port held at zero.
    for (int i = 0; i < 3; i++) step(1'b1, 4'b1111, 4'b0000, 4'b0000, "reset");

    // Fairness from reset: 0,1,2,3,0,1,2,3 with mixed reads/writes.
    for (int k = 0; k < N; k++) set_port(k, 32'h20 + k, $urandom);
    for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, 4'b1010, onehot(i % N), "fair");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'b0000, 4'b0000, "drain1");

    // Single write from requester 2.
    set_port(2, 32'h10, 32'hDEAD_BEEF);
    step(1'b0, 4'b0100, 4'b0100, 4'b0100, "wr2");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, "wr2_idle");

    // Single read of the same address from requester 1.
    set_port(1, 32'h10, 32'h0);
    step(1'b0, 4'b0010, 4'b0000, 4'b0010, "rd1");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'b0000, 4'b0000, "rd1_wait");

    // Wrap and skip: bring ptr to 3, then requesters 0 and 2 alternate.
    set_port(2, 32'h50, 32'h5555_0002);
    step(1'b0, 4'b0100, 4'b0100, 4'b0100, "ptr3");
    set_port(0, 32'h50, 32'h0);
    step(1'b0, 4'b0101, 4'b0100, 4'b0001, "wrap0");
    set_port(2, 32'h51, 32'h5555_0051);
    step(1'b0, 4'b0101, 4'b0100, 4'b0100, "skip2");
    step(1'b0, 4'b0101, 4'b0100, 4'b0001, "wrap0b");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'b0000, 4'b0000, "drain2");

    // Interleaved read / write / read: responses in issue order.
    set_port(0, 32'h30, 32'h0);
    set_port(3, 32'h30, 32'h1234_5678);
    step(1'b0, 4'b0001, 4'b0000, 4'b0001, "il_rd0");
    step(1'b0, 4'b1000, 4'b1000, 4'b1000, "il_wr3");
    step(1'b0, 4'b0001, 4'b0000, 4'b0001, "il_rd0b");
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, 4'b0000, 4'b0000, "drain3");

    // Same sequence with reset one cycle after the second read issues.
    set_port(3, 32'h30, 32'hCAFE_F00D);
    step(1'b0, 4'b0001, 4'b0000, 4'b0001, "rs_rd0");
    step(1'b0, 4'b1000, 4'b1000, 4'b1000, "rs_wr3");
    step(1'b0, 4'b0001, 4'b0000, 4'b0001, "rs_rd0b");
    step(1'b0, 4'b0000, 4'b0000, 4'b0000, "rs_issue");
    step(1'b1, 4'b0000, 4'b0000, 4'b0000, "rs_pulse");
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, 4'b0000, 4'b0000, "rs_quiet");
    step(1'b0, 4'b1111, 4'b0000, 4'b0001, "post_rst");
    for (int i = 0; i < 5; i++) step(1'b0, 4'b0000, 4'b0000, 4'b0000, "drain4");

    // Random traffic against a round-robin reference.
    for (int i = 0; i < 24; i++) begin
      for (int k = 0; k < N; k++) set_port(k, 32'h40 + $urandom_range(0, 15), $urandom);
      rq = 4'($urandom_range(0, 15));
      wr = 4'($urandom_range(0, 15));
      step(1'b0, rq, wr, rr_pick(m_ptr, rq), "rand");
    end
    for (int i = 0; i < 6; i++) step(1'b0, 4'b0000, 4'b0000, 4'b0000, "drain5");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
